// File: rtl/jtframe_sdram_mux.sv
// Round-robin read multiplexer sharing one SDRAM port among CH ROM clients,
// with a one-entry address cache per channel, download gating and a timeout.
module jtframe_sdram_mux #(
  parameter int unsigned CH      = 4,
  parameter int unsigned AW      = 22,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_rom,
  input  logic             rst_n,
  input  logic             downloading,
  input  logic [CH-1:0]    ch_req,
  input  logic [CH*AW-1:0] ch_addr,
  output logic [CH-1:0]    ch_ok,
  output logic [DW-1:0]    ch_data,
  output logic             sdram_req,
  output logic [AW-1:0]    sdram_addr,
  input  logic             sdram_ack,
  input  logic [DW-1:0]    data_read,
  input  logic             data_rdy,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned RW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned CW = 10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rr_q, rr_d;
  logic [RW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CH-1:0]   ch_ok_q, ch_ok_d;
  logic [DW-1:0]   ch_data_q, ch_data_d;
  logic            sdram_req_q, sdram_req_d;
  logic [AW-1:0]   sdram_addr_q, sdram_addr_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [CH-1:0]   cache_vld_q, cache_vld_d;
  logic [AW-1:0]   cache_addr_q [CH];
  logic [AW-1:0]   cache_addr_d [CH];
  logic [DW-1:0]   cache_data_q [CH];
  logic [DW-1:0]   cache_data_d [CH];

  logic [AW-1:0]   req_addr_c [CH];
  logic            gnt_vld_c;
  logic [RW-1:0]   gnt_idx_c;
  logic            hit_c;
  logic [CW-1:0]   cnt_inc_c;

  function automatic logic [RW-1:0] wrap(input logic [RW:0] v);
    return (v >= (RW+1)'(CH)) ? RW'(v - (RW+1)'(CH)) : RW'(v);
  endfunction

  // Unpack addresses; the search walks down so the lowest offset from rr wins.
  always_comb begin
    for (int k = 0; k < int'(CH); k++) begin
      req_addr_c[k] = ch_addr[k*AW +: AW];
    end
    gnt_vld_c = 1'b0;
    gnt_idx_c = rr_q;
    for (int i = int'(CH) - 1; i >= 0; i--) begin
      if (ch_req[wrap({1'b0, rr_q} + (RW+1)'(i))]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = wrap({1'b0, rr_q} + (RW+1)'(i));
      end
    end
    hit_c     = cache_vld_q[gnt_idx_c] && (cache_addr_q[gnt_idx_c] == req_addr_c[gnt_idx_c]);
    cnt_inc_c = cnt_q + CW'(1);
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    ch_ok_d      = '0;
    ch_data_d    = ch_data_q;
    sdram_addr_d = sdram_addr_q;
    timeout_d    = 1'b0;
    cache_vld_d  = cache_vld_q;
    cache_addr_d = cache_addr_q;
    cache_data_d = cache_data_q;

    case (state_q)
      IDLE: begin
        if (!downloading && gnt_vld_c) begin
          sel_d = gnt_idx_c;
          rr_d  = wrap({1'b0, gnt_idx_c} + (RW+1)'(1));
          if (hit_c) begin
            state_d              = DONE;
            ch_data_d            = cache_data_q[gnt_idx_c];
            ch_ok_d[gnt_idx_c]   = 1'b1;
          end else begin
            state_d      = REQ;
            sdram_addr_d = req_addr_c[gnt_idx_c];
            cnt_d        = '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc_c;
        if (cnt_inc_c >= CW'(TIMEOUT)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (sdram_ack) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc_c;
        if (cnt_inc_c >= CW'(TIMEOUT)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (data_rdy) begin
          state_d        = DONE;
          ch_data_d      = data_read;
          ch_ok_d[sel_q] = 1'b1;
          if (!downloading) begin
            cache_vld_d[sel_q]  = 1'b1;
            cache_addr_d[sel_q] = sdram_addr_q;
            cache_data_d[sel_q] = data_read;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A download may rewrite any ROM region, so every entry goes stale.
    if (downloading) cache_vld_d = '0;

    sdram_req_d = (state_d == REQ);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      ch_ok_q      <= '0;
      ch_data_q    <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cache_vld_q  <= '0;
      for (int k = 0; k < int'(CH); k++) begin
        cache_addr_q[k] <= '0;
        cache_data_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      ch_ok_q      <= ch_ok_d;
      ch_data_q    <= ch_data_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      cache_vld_q  <= cache_vld_d;
      cache_addr_q <= cache_addr_d;
      cache_data_q <= cache_data_d;
    end
  end

  assign ch_ok      = ch_ok_q;
  assign ch_data    = ch_data_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;

endmodule
